dcntl_update_ctrl: RTL and testbench
====================================

Name: dcntl_update_ctrl

Overview:
- Consumer side of the DLL delay-code interface. It drives UDDCNTL toward the DLL and captures the 9-bit DCNTL code the DLL returns.
- It periodically opens an update window and waits for the code to settle. It then requires several identical samples and applies slew limiting before committing the code to downstream slave delay cells.
- It sits between the DLL primitive and the DQS/slave delay-line logic, in the CLKIB domain.

Parameters:
- UPD_INTERVAL, 256: CLKIB cycles spent in WAIT between update windows (min 4).
- UPD_WIDTH, 4: CLKIB cycles that UDDCNTL is held high per window (min 1).
- MATCH_CNT, 3: consecutive identical synchronized samples required to commit (min 1).
- SAMPLE_MAX, 16: SAMPLE-state timeout in cycles (must be ≥ MATCH_CNT).
- MAX_STEP, 16: maximum allowed |new − current| code change after the first commit.

Ports:
- CLKIB  in  1  DLL reference clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- LOCK  in  1  DLL lock; asynchronous, 2-flop synchronized to lock_s.
- DCNTL  in  9  DLL delay code; quasi-static, 2-flop synchronized to dc_s.
- FREEZE  in  1  when high, suppresses the start of new update windows.
- UDDCNTL  out  1  update-enable to the DLL.
- DCODE  out  9  committed delay code.
- DCODE_VALID  out  1  DCODE holds a code committed since the last lock.
- DCODE_CHG  out  1  one-cycle pulse when DCODE changes value.
- STEP_ERR  out  1  one-cycle pulse on a slew-rejected commit or a SAMPLE timeout.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0 (DCODE=0).
  - FSM=IDLE; all counters and synchronizers cleared.
- FSM states: IDLE, WAIT, UPDATE, SETTLE, SAMPLE.
- IDLE:
  - UDDCNTL=0.
  - On lock_s=1 go directly to UPDATE, skipping the interval.
- WAIT:
  - Interval counter counts up from 0.
  - At UPD_INTERVAL−1, go to UPDATE.
  - While FREEZE=1 the counter holds and no transition occurs.
- UPDATE:
  - UDDCNTL=1 for exactly UPD_WIDTH cycles, then SETTLE.
  - FREEZE asserted inside UPDATE does not shorten the window.
- SETTLE:
  - UDDCNTL=0 for 2 cycles (synchronizer flush), then SAMPLE.
  - The previous-sample register is cleared to invalid.
- SAMPLE (each cycle):
  - If dc_s equals the previous sample, match counter +1; otherwise counter=1 and previous=dc_s.
  - When the counter reaches MATCH_CNT → commit.
  - If SAMPLE_MAX cycles elapse without a commit → pulse STEP_ERR, DCODE unchanged, go to WAIT.
- Commit rules:
  - DCODE_VALID=0: DCODE←sample; DCODE_VALID←1; DCODE_CHG pulses if the value differs from the old DCODE.
  - DCODE_VALID=1 and |sample−DCODE| ≤ MAX_STEP: DCODE←sample; DCODE_CHG pulses only if the value differs.
  - DCODE_VALID=1 and |sample−DCODE| > MAX_STEP: DCODE held; STEP_ERR pulses.
  - Difference is computed on 10-bit unsigned magnitude; no wrap.
  - After commit, go to WAIT with the interval counter at 0.
  - DCODE and pulses update on the cycle after the MATCH_CNT-th matching sample.
- Lock loss: lock_s=0 in any non-IDLE state, next cycle:
  - FSM=IDLE, UDDCNTL=0, DCODE_VALID=0.
  - DCODE holds its last value; no pulses.
  - Relock restarts at UPDATE; the first commit is unrestricted.
- Priority on the same cycle: lock loss > timeout > commit.
- DCODE_CHG and STEP_ERR are never high on the same cycle.
- Latency: LOCK rise → UDDCNTL rise = 3 cycles (2 sync + 1 FSM).

Test Plan:
1. Reset, LOCK=1, DCNTL=9'h050 static → UDDCNTL high 4 cycles starting 3 cycles after LOCK; DCODE=0x050, DCODE_VALID=1, one DCODE_CHG pulse; next UDDCNTL 256 WAIT cycles later.
2. After commit of 0x050, DCNTL→0x058 → next window commits 0x058 with DCODE_CHG; unchanged code on the following window → no DCODE_CHG.
3. DCODE=0x050, DCNTL→0x070 (step 32 > 16) → STEP_ERR one cycle, DCODE stays 0x050, DCODE_VALID stays 1.
4. DCNTL toggles between 0x050 and 0x051 every cycle during SAMPLE → no commit; STEP_ERR after 16 SAMPLE cycles; FSM returns to WAIT.
5. FREEZE=1 mid-WAIT for 100 cycles → UDDCNTL rise delayed by exactly 100 cycles; FREEZE rising inside UPDATE → UDDCNTL still high 4 cycles.
6. LOCK drops during UPDATE → UDDCNTL low and DCODE_VALID=0 within 3 cycles, DCODE retained; relock with DCNTL=0x100 → commits 0x100 despite step >16; async resetn mid-SAMPLE → all outputs 0 immediately.

Source files
------------

// File: rtl/dcntl_update_ctrl_if.sv
// dcntl_update_ctrl_if
//   DLL delay-code bundle between the DLL side (master) and the update
//   controller (slave).
//   LOCK        DLL lock, asynchronous to CLKIB
//   DCNTL[8:0]  quasi-static delay code from the DLL
//   FREEZE      holds off new update windows
//   UDDCNTL     update-enable back to the DLL
//   DCODE[8:0]  committed code for the slave delay cells
//   DCODE_VALID DCODE committed since the last lock
//   DCODE_CHG   one-cycle pulse when DCODE changes
//   STEP_ERR    one-cycle pulse on slew-rejected commit or sample timeout
interface dcntl_update_ctrl_if;
  logic       LOCK;
  logic [8:0] DCNTL;
  logic       FREEZE;
  logic       UDDCNTL;
  logic [8:0] DCODE;
  logic       DCODE_VALID;
  logic       DCODE_CHG;
  logic       STEP_ERR;

  modport master (
    output LOCK, DCNTL, FREEZE,
    input  UDDCNTL, DCODE, DCODE_VALID, DCODE_CHG, STEP_ERR
  );

  modport slave (
    input  LOCK, DCNTL, FREEZE,
    output UDDCNTL, DCODE, DCODE_VALID, DCODE_CHG, STEP_ERR
  );
endinterface

// File: rtl/dcntl_update_ctrl.sv
// dcntl_update_ctrl
//   Opens periodic UDDCNTL windows toward the DLL, waits for the returned
//   code to settle, requires MATCH_CNT identical synchronized samples and
//   slew-limits the result before committing it to DCODE.
//   CLKIB   reference clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     dcntl_update_ctrl_if.slave (LOCK/DCNTL/FREEZE in, code/status out)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no lock; UDDCNTL low, waits for lock_s
// ST_WAIT   | interval timer between windows, held while FREEZE
// ST_UPDATE | UDDCNTL high for UPD_WIDTH cycles
// ST_SETTLE | 2 cycles to flush the DCNTL synchronizer
// ST_SAMPLE | match identical samples, commit or time out
module dcntl_update_ctrl #(
  parameter int UPD_INTERVAL = 256,
  parameter int UPD_WIDTH    = 4,
  parameter int MATCH_CNT    = 3,
  parameter int SAMPLE_MAX   = 16,
  parameter int MAX_STEP     = 16
) (
  input logic                CLKIB,
  input logic                resetn,
  dcntl_update_ctrl_if.slave bus
);

  localparam int TMR_A   = (UPD_INTERVAL > UPD_WIDTH) ? UPD_INTERVAL : UPD_WIDTH;
  localparam int TMR_MAX = (TMR_A > SAMPLE_MAX) ? TMR_A : SAMPLE_MAX;
  localparam int TW      = $clog2(TMR_MAX);
  localparam int MW      = $clog2(MATCH_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_UPDATE, ST_SETTLE, ST_SAMPLE
  } state_t;

  state_t        r_state;
  logic          r_lock_m, r_lock_s;
  logic [8:0]    r_dc_m, r_dc_s;
  logic [TW-1:0] r_tmr;
  logic [MW-1:0] r_match;
  logic [8:0]    r_prev;
  logic          r_prev_vld;
  logic          r_ud;
  logic [8:0]    r_dcode;
  logic          r_valid;
  logic          r_chg;
  logic          r_err;

  logic [MW-1:0] w_match_nxt;
  logic [9:0]    w_diff;
  logic          w_step_ok;
  logic          w_tmr_tc;

  always_ff @(posedge CLKIB or negedge resetn) begin
    if (!resetn) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
      r_dc_m   <= '0;
      r_dc_s   <= '0;
    end else begin
      r_lock_m <= bus.LOCK;
      r_lock_s <= r_lock_m;
      r_dc_m   <= bus.DCNTL;
      r_dc_s   <= r_dc_m;
    end
  end

  always_comb begin
    w_match_nxt = (r_prev_vld && (r_dc_s == r_prev)) ? r_match + MW'(1) : MW'(1);
    // Magnitude on 10 bits so the subtraction never wraps.
    w_diff = ({1'b0, r_dc_s} >= {1'b0, r_dcode}) ? ({1'b0, r_dc_s} - {1'b0, r_dcode})
                                                 : ({1'b0, r_dcode} - {1'b0, r_dc_s});
    w_step_ok = !r_valid || (w_diff <= 10'(MAX_STEP));
    w_tmr_tc  = (r_tmr == '0);
  end

  always_ff @(posedge CLKIB or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_match    <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_ud       <= 1'b0;
      r_dcode    <= '0;
      r_valid    <= 1'b0;
      r_chg      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      r_err <= 1'b0;
      // Lock loss overrides everything; DCODE is kept for the slave cells.
      if ((r_state != ST_IDLE) && !r_lock_s) begin
        r_state <= ST_IDLE;
        r_ud    <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_lock_s) begin
              r_state <= ST_UPDATE;
              r_ud    <= 1'b1;
              r_tmr   <= TW'(UPD_WIDTH - 1);
            end
          end
          ST_WAIT: begin
            if (!bus.FREEZE) begin
              if (w_tmr_tc) begin
                r_state <= ST_UPDATE;
                r_ud    <= 1'b1;
                r_tmr   <= TW'(UPD_WIDTH - 1);
              end else begin
                r_tmr <= r_tmr - TW'(1);
              end
            end
          end
          ST_UPDATE: begin
            if (w_tmr_tc) begin
              r_state    <= ST_SETTLE;
              r_ud       <= 1'b0;
              r_tmr      <= TW'(1);
              r_prev_vld <= 1'b0;
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
          ST_SETTLE: begin
            r_prev_vld <= 1'b0;
            if (w_tmr_tc) begin
              r_state <= ST_SAMPLE;
              r_tmr   <= TW'(SAMPLE_MAX - 1);
              r_match <= '0;
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
          ST_SAMPLE: begin
            r_match    <= w_match_nxt;
            r_prev     <= r_dc_s;
            r_prev_vld <= 1'b1;
            // Timeout wins over a commit landing on the last sample cycle.
            if (w_tmr_tc) begin
              r_err   <= 1'b1;
              r_state <= ST_WAIT;
              r_tmr   <= TW'(UPD_INTERVAL - 1);
            end else if (w_match_nxt == MW'(MATCH_CNT)) begin
              if (w_step_ok) begin
                r_dcode <= r_dc_s;
                r_valid <= 1'b1;
                r_chg   <= (r_dc_s != r_dcode);
              end else begin
                r_err <= 1'b1;
              end
              r_state <= ST_WAIT;
              r_tmr   <= TW'(UPD_INTERVAL - 1);
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.UDDCNTL     = r_ud;
  assign bus.DCODE       = r_dcode;
  assign bus.DCODE_VALID = r_valid;
  assign bus.DCODE_CHG   = r_chg;
  assign bus.STEP_ERR    = r_err;

endmodule

// File: tb/tb_dcntl_update_ctrl.sv
// tb_dcntl_update_ctrl
//   Scoreboard bench: each window pushes the expected UDDCNTL rise and
//   DCODE_CHG/STEP_ERR events (cycle, code, valid); a negedge monitor pops
//   and compares them as the DUT produces them.
module tb_dcntl_update_ctrl;
  localparam int UPD_INTERVAL = 256;
  localparam int UPD_WIDTH    = 4;
  localparam int MATCH_CNT    = 3;
  localparam int SAMPLE_MAX   = 16;
  localparam int MAX_STEP     = 16;

  localparam int EV_NONE = 0;
  localparam int EV_UD   = 1;
  localparam int EV_CHG  = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [8:0] code;
    logic       valid;
  } ev_t;

  logic CLKIB = 1'b0;
  logic resetn;

  dcntl_update_ctrl_if bus ();

  dcntl_update_ctrl #(
    .UPD_INTERVAL (UPD_INTERVAL),
    .UPD_WIDTH    (UPD_WIDTH),
    .MATCH_CNT    (MATCH_CNT),
    .SAMPLE_MAX   (SAMPLE_MAX),
    .MAX_STEP     (MAX_STEP)
  ) dut (
    .CLKIB  (CLKIB),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 CLKIB = ~CLKIB;

  int cyc = 0;
  always @(posedge CLKIB) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  ev_t        sb_q[$];
  int         ud_w     = 0;
  int         exp_ud_w = UPD_WIDTH;
  logic       ud_q     = 1'b0;
  bit         tog_en   = 1'b0;
  logic [8:0] m_dcode;
  logic       m_valid;
  int         t_rise;

  task automatic push(input int kind, input int t, input logic [8:0] code, input logic valid);
    ev_t e;
    e.kind  = kind;
    e.cyc   = t;
    e.code  = code;
    e.valid = valid;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      chk("ev_unexpected", kind, EV_NONE);
    end else begin
      e = sb_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_dcode", bus.DCODE, e.code);
      chk("ev_valid", bus.DCODE_VALID, e.valid);
    end
  endtask

  always @(negedge CLKIB) begin
    if (resetn === 1'b1) begin
      if (bus.UDDCNTL && !ud_q) sb_pop(EV_UD);
      if (bus.DCODE_CHG) sb_pop(EV_CHG);
      if (bus.STEP_ERR) sb_pop(EV_ERR);
      if (bus.DCODE_CHG || bus.STEP_ERR) chk("chg_err_excl", bus.DCODE_CHG & bus.STEP_ERR, 0);
      if (bus.UDDCNTL) ud_w++;
      else if (ud_w != 0) begin
        chk("ud_width", ud_w, exp_ud_w);
        ud_w = 0;
      end
      ud_q = bus.UDDCNTL;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLKIB);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // One update window starting with the UDDCNTL rise at t_rise.
  task automatic window(input logic [8:0] code, input bit timeout, input bit frz_upd);
    int t_pulse;
    push(EV_UD, t_rise, m_dcode, m_valid);
    if (frz_upd) begin
      wait_until(t_rise + 1);
      bus.FREEZE = 1'b1;
      step(4);
      bus.FREEZE = 1'b0;
    end
    if (timeout) begin
      t_pulse = t_rise + UPD_WIDTH + 2 + SAMPLE_MAX;
      push(EV_ERR, t_pulse, m_dcode, m_valid);
    end else begin
      t_pulse = t_rise + UPD_WIDTH + 2 + MATCH_CNT;
      if (!m_valid || absdiff(int'(code), int'(m_dcode)) <= MAX_STEP) begin
        if (code != m_dcode) push(EV_CHG, t_pulse, code, 1'b1);
        m_dcode = code;
        m_valid = 1'b1;
      end else begin
        push(EV_ERR, t_pulse, m_dcode, m_valid);
      end
    end
    wait_until(t_pulse + 1);
    chk("win_dcode", bus.DCODE, m_dcode);
    chk("win_valid", bus.DCODE_VALID, m_valid);
    chk("win_sb_drained", sb_q.size(), 0);
    t_rise = t_pulse + UPD_INTERVAL;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    bus.LOCK   = 1'b0;
    bus.DCNTL  = 9'h050;
    bus.FREEZE = 1'b0;
    m_dcode    = 9'h000;
    m_valid    = 1'b0;
    step(3);
    chk("rst_ud", bus.UDDCNTL, 0);
    chk("rst_dcode", bus.DCODE, 0);
    chk("rst_valid", bus.DCODE_VALID, 0);
    chk("rst_chg", bus.DCODE_CHG, 0);
    chk("rst_err", bus.STEP_ERR, 0);
    resetn = 1'b1;
    step(5);
    chk("idle_no_lock_ud", bus.UDDCNTL, 0);

    // First lock: window right away, 3 cycles after LOCK.
    bus.LOCK = 1'b1;
    t_rise   = cyc + 3;
    window(9'h050, 1'b0, 1'b0);

    // Small step commits, unchanged code commits silently.
    bus.DCNTL = 9'h058;
    window(9'h058, 1'b0, 1'b0);
    window(9'h058, 1'b0, 1'b0);
    bus.DCNTL = 9'h050;
    window(9'h050, 1'b0, 1'b0);

    // Step of 32 is rejected.
    bus.DCNTL = 9'h070;
    window(9'h070, 1'b0, 1'b0);

    // Code toggling every cycle never matches: sample timeout.
    bus.DCNTL = 9'h050;
    tog_en    = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge CLKIB);
          #1;
          if (tog_en) bus.DCNTL = bus.DCNTL ^ 9'h001;
        end
      end
    join_none
    window(9'h000, 1'b1, 1'b0);
    tog_en = 1'b0;
    step(2);
    bus.DCNTL = 9'h052;

    // FREEZE for 100 WAIT cycles, then FREEZE raised inside UPDATE.
    step(40);
    bus.FREEZE = 1'b1;
    step(100);
    bus.FREEZE = 1'b0;
    t_rise     = t_rise + 100;
    window(9'h052, 1'b0, 1'b1);

    // Lock loss right after the window opens.
    push(EV_UD, t_rise, m_dcode, m_valid);
    exp_ud_w = 3;
    wait_until(t_rise);
    bus.LOCK = 1'b0;
    step(2);
    chk("ll_ud_before", bus.UDDCNTL, 1);
    step(1);
    chk("ll_ud", bus.UDDCNTL, 0);
    chk("ll_valid", bus.DCODE_VALID, 0);
    chk("ll_dcode_kept", bus.DCODE, m_dcode);
    m_valid = 1'b0;
    step(1);
    exp_ud_w = UPD_WIDTH;
    step(10);
    chk("ll_idle_ud", bus.UDDCNTL, 0);
    chk("ll_sb_drained", sb_q.size(), 0);

    // Relock: first commit unrestricted despite a large step.
    bus.DCNTL = 9'h100;
    step(5);
    bus.LOCK = 1'b1;
    t_rise   = cyc + 3;
    window(9'h100, 1'b0, 1'b0);

    // Async reset in the middle of SAMPLE.
    push(EV_UD, t_rise, m_dcode, m_valid);
    wait_until(t_rise + UPD_WIDTH + 4);
    chk("pre_rst_dcode", bus.DCODE, 9'h100);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_ud", bus.UDDCNTL, 0);
    chk("arst_dcode", bus.DCODE, 0);
    chk("arst_valid", bus.DCODE_VALID, 0);
    chk("arst_chg", bus.DCODE_CHG, 0);
    chk("arst_err", bus.STEP_ERR, 0);
    chk("arst_sb_drained", sb_q.size(), 0);
    step(3);
    chk("arst_hold_dcode", bus.DCODE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
